// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters. It grants
// requests round-robin and executes one operation at a time. Each accepted
// operation spends one cycle in EXEC, where the external ALU is driven and its
// result is captured. It then waits in RESP until the granted requester takes
// the result.
//
// Ports
//   clk                    single clock, rising edge
//   rst                    synchronous, active-high reset
//   req0_valid/req1_valid  requester N has an operation pending
//   req0_ready/req1_ready  operation accepted when valid & ready
//   req0_a/b, req1_a/b     4-bit operands
//   req0_sel, req1_sel     3-bit ALU opcode
//   rsp0_valid/rsp1_valid  result available for requester N
//   rsp0_ready/rsp1_ready  requester N consumes the result
//   rsp_data               captured 5-bit ALU result, shared by both requesters
//   alu_a/alu_b/alu_sel    drive the external ALU (zero outside EXEC)
//   alu_out                result from the external ALU
//   busy                   high in any state other than IDLE
//   ops_done               count of completed response handshakes (wraps)
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic [2:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic [2:0]       req1_sel,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [4:0]       rsp_data,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_sel,
    input  logic [4:0]       alu_out,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic       last_grant;   // ID served by the most recent response handshake
    logic       grant;        // requester selected this cycle while in IDLE
    logic       any_valid;
    logic       accept;
    logic       rsp_hs;

    logic [3:0] lat_a;
    logic [3:0] lat_b;
    logic [2:0] lat_sel;
    logic       lat_id;

    // Round-robin: a lone requester wins. Under contention, the requester that
    // was not served last wins.
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant     = 1'b0;
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Ready is combinational in IDLE and is forced low while reset is held.
    assign req0_ready = !rst && (state == IDLE) && any_valid && !grant;
    assign req1_ready = !rst && (state == IDLE) && any_valid &&  grant;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign rsp0_valid = (state == RESP) && !lat_id;
    assign rsp1_valid = (state == RESP) &&  lat_id;
    // Only the granted requester's ready completes the response.
    assign rsp_hs     = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    assign busy = (state != IDLE);

    // The external ALU sees the latched operation only during EXEC.
    assign alu_a   = (state == EXEC) ? lat_a   : 4'd0;
    assign alu_b   = (state == EXEC) ? lat_b   : 4'd0;
    assign alu_sel = (state == EXEC) ? lat_sel : 3'd0;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values and the order of statements does not matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;   // requester 0 wins the first contention
            lat_a      <= 4'd0;
            lat_b      <= 4'd0;
            lat_sel    <= 3'd0;
            lat_id     <= 1'b0;
            rsp_data   <= 5'd0;
            ops_done   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Latch everything so a valid dropping after acceptance
                        // cannot disturb the operation in flight.
                        lat_a   <= grant ? req1_a   : req0_a;
                        lat_b   <= grant ? req1_b   : req0_b;
                        lat_sel <= grant ? req1_sel : req0_sel;
                        lat_id  <= grant;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data <= alu_out;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_hs) begin
                        last_grant <= lat_id;
                        ops_done   <= ops_done + CNT_W'(1);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. A second instance with CNT_W=2 shares all
// inputs so the counter wrap can be observed alongside the default instance.
// The external ALU is modelled as a function. Expected results are
// hand-computed constants.
// ALU model: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not a, 6 a<<1, 7 a>>1.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_sel, req1_sel;
    logic       rsp0_ready, rsp1_ready;

    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [4:0] rsp_data, alu_out;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_sel;
    logic [7:0] ops_done;

    logic       w_req0_ready, w_req1_ready, w_rsp0_valid, w_rsp1_valid, w_busy;
    logic [4:0] w_rsp_data, w_alu_out;
    logic [3:0] w_alu_a, w_alu_b;
    logic [2:0] w_alu_sel;
    logic [1:0] w_ops_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] s);
        case (s)
            3'd0:    alu_f = {1'b0, a} + {1'b0, b};
            3'd1:    alu_f = {1'b0, a} - {1'b0, b};
            3'd2:    alu_f = {1'b0, a & b};
            3'd3:    alu_f = {1'b0, a | b};
            3'd4:    alu_f = {1'b0, a ^ b};
            3'd5:    alu_f = {1'b0, ~a};
            3'd6:    alu_f = {a, 1'b0};
            default: alu_f = {2'b00, a[3:1]};
        endcase
    endfunction

    assign alu_out   = alu_f(alu_a, alu_b, alu_sel);
    assign w_alu_out = alu_f(w_alu_a, w_alu_b, w_alu_sel);

    alu_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
        .busy(busy), .ops_done(ops_done)
    );

    alu_arbiter #(.CNT_W(2)) dut_w (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(w_req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(w_req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .rsp0_valid(w_rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(w_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(w_rsp_data),
        .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_sel(w_alu_sel), .alu_out(w_alu_out),
        .busy(w_busy), .ops_done(w_ops_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] sweep_exp [8];

    initial begin
        sweep_exp[0] = 5'h12;  // 1011 + 0111
        sweep_exp[1] = 5'h04;  // 1011 - 0111
        sweep_exp[2] = 5'h03;  // and
        sweep_exp[3] = 5'h0F;  // or
        sweep_exp[4] = 5'h0C;  // xor
        sweep_exp[5] = 5'h04;  // ~1011
        sweep_exp[6] = 5'h16;  // 1011 << 1
        sweep_exp[7] = 5'h05;  // 1011 >> 1

        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_a = 4'd0; req0_b = 4'd0; req0_sel = 3'd0;
        req1_a = 4'd0; req1_b = 4'd0; req1_sel = 3'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;

        // ---------------- reset ----------------
        tick();
        check("rst_req0_ready", 32'(req0_ready), 0);
        check("rst_req1_ready", 32'(req1_ready), 0);
        tick();
        rst = 1'b0;
        req0_valid = 1'b0;
        #1;
        check("rst_rsp0_valid", 32'(rsp0_valid), 0);
        check("rst_rsp1_valid", 32'(rsp1_valid), 0);
        check("rst_rsp_data",   32'(rsp_data), 0);
        check("rst_ops_done",   32'(ops_done), 0);
        check("rst_busy",       32'(busy), 0);
        check("rst_alu",        32'({alu_a, alu_b, alu_sel}), 0);

        // ---------------- single-op latency ----------------
        req0_valid = 1'b1; req0_a = 4'b1011; req0_b = 4'b0111; req0_sel = 3'b000;
        #1;
        check("t1_req0_ready", 32'(req0_ready), 1);
        check("t1_req1_ready", 32'(req1_ready), 0);
        tick();                           // accepted at T
        req0_valid = 1'b0;                // dropping valid must not matter
        #1;
        check("t1_busy_exec",  32'(busy), 1);
        check("t1_alu_a",      32'(alu_a), 32'hB);
        check("t1_alu_b",      32'(alu_b), 32'h7);
        check("t1_alu_sel",    32'(alu_sel), 0);
        check("t1_ready_exec", 32'(req0_ready), 0);
        tick();                           // T+2
        check("t1_rsp0_valid", 32'(rsp0_valid), 1);
        check("t1_rsp1_valid", 32'(rsp1_valid), 0);
        check("t1_rsp_data",   32'(rsp_data), 32'h12);
        check("t1_alu_resp",   32'({alu_a, alu_b, alu_sel}), 0);
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        check("t1_ops_done",   32'(ops_done), 1);
        check("t1_busy_idle",  32'(busy), 0);
        check("t1_rsp0_drop",  32'(rsp0_valid), 0);
        check("t1_data_hold",  32'(rsp_data), 32'h12);

        // ---------------- reset mid-operation ----------------
        // last_grant is now 0; a lone req1 is accepted, then reset hits EXEC.
        req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd2; req1_sel = 3'd0;
        #1;
        check("rm_req1_ready", 32'(req1_ready), 1);
        tick();
        req1_valid = 1'b0;
        #1;
        check("rm_busy_exec", 32'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rm_busy",       32'(busy), 0);
        check("rm_rsp_valids", 32'({rsp0_valid, rsp1_valid}), 0);
        check("rm_ops_done",   32'(ops_done), 0);
        check("rm_rsp_data",   32'(rsp_data), 0);
        check("rm_alu",        32'({alu_a, alu_b, alu_sel}), 0);

        // ---------------- contention ----------------
        // Accept every third cycle starting at k=0; response valid at k=2,5,8,11.
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2; req0_sel = 3'd0;  // -> 3
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd4; req1_sel = 3'd0;  // -> 9
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        for (int k = 0; k < 12; k++) begin
            automatic int g = (k / 3) % 2;
            case (k % 3)
                0: begin
                    check("ct_req0_ready", 32'(req0_ready), (g == 0) ? 1 : 0);
                    check("ct_req1_ready", 32'(req1_ready), (g == 1) ? 1 : 0);
                end
                1: begin
                    check("ct_busy_exec", 32'(busy), 1);
                    check("ct_alu_a",     32'(alu_a), (g == 1) ? 5 : 1);
                    check("ct_rsp_none",  32'({rsp0_valid, rsp1_valid}), 0);
                end
                default: begin
                    check("ct_rsp0_valid", 32'(rsp0_valid), (g == 0) ? 1 : 0);
                    check("ct_rsp1_valid", 32'(rsp1_valid), (g == 1) ? 1 : 0);
                    check("ct_rsp_data",   32'(rsp_data), (g == 1) ? 9 : 3);
                end
            endcase
            tick();
            if (k % 3 == 2) begin
                check("ct_ops_done",   32'(ops_done), (k / 3) + 1);
                check("wrap_ops_done", 32'(w_ops_done), ((k / 3) + 1) % 4);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        check("ct_ops_final", 32'(ops_done), 4);

        // ---------------- response backpressure ----------------
        req1_valid = 1'b1; req1_a = 4'b1011; req1_b = 4'b0111; req1_sel = 3'd1;  // -> 4
        #1;
        check("bp_req1_ready", 32'(req1_ready), 1);
        tick();
        req1_valid = 1'b0;
        tick();                           // now in RESP
        req0_valid = 1'b1;                // competing request must wait
        rsp0_ready = 1'b1;                // wrong requester's ready has no effect
        #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp1_valid", 32'(rsp1_valid), 1);
            check("bp_rsp0_valid", 32'(rsp0_valid), 0);
            check("bp_rsp_data",   32'(rsp_data), 4);
            check("bp_req0_ready", 32'(req0_ready), 0);
            check("bp_busy",       32'(busy), 1);
            tick();
        end
        req0_valid = 1'b0; rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        check("bp_ops_done",   32'(ops_done), 5);
        check("bp_busy_idle",  32'(busy), 0);
        check("wrap_ops_five", 32'(w_ops_done), 1);

        // ---------------- opcode sweep ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req1_a = 4'b1011; req1_b = 4'b0111;
        rsp1_ready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            req1_valid = 1'b1;
            req1_sel   = 3'(s);
            #1;
            check("sw_req1_ready", 32'(req1_ready), 1);
            tick();
            req1_valid = 1'b0;
            #1;
            check("sw_alu_sel", 32'(alu_sel), s);
            tick();
            check("sw_rsp1_valid", 32'(rsp1_valid), 1);
            check("sw_rsp_data",   32'(rsp_data), 32'(sweep_exp[s]));
            tick();
        end
        rsp1_ready = 1'b0;
        check("sw_ops_done", 32'(ops_done), 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends on its own.
    initial begin
        #100000;
        $display("FAIL timeout: observed=no_finish expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 8, width of the completed-operation counter.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have ports req0_valid / req1_valid, input, 1 each, requester N has an operation pending.
REQ-005 The block SHALL have ports req0_ready / req1_ready, output, 1 each, operation accepted when valid and ready are both high.
REQ-006 The block SHALL have ports req0_a, req0_b / req1_a, req1_b, input, 4 each, operands.
REQ-007 The block SHALL have ports req0_sel / req1_sel, input, 3 each, ALU opcode.
REQ-008 The block SHALL have ports rsp0_valid / rsp1_valid, output, 1 each, result available for requester N.
REQ-009 The block SHALL have ports rsp0_ready / rsp1_ready, input, 1 each, requester N consumes the result.
REQ-010 The block SHALL have port rsp_data, output, 5, captured ALU result, shared by both responders.
REQ-011 The block SHALL have ports alu_a / alu_b, output, 4 each, and alu_sel, output, 3; these drive the existing ALU module.
REQ-012 The block SHALL have port alu_out, input, 5, the ALU module's result.
REQ-013 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 The block SHALL have port ops_done, output, CNT_W, count of completed response handshakes.

Function
REQ-015 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-016 In IDLE, the block SHALL assert reqN_ready combinationally for exactly one requester: the granted requester, if any valid is high.
- REQ-017 Grant SHALL be round-robin:
  - if only one requester is valid, that requester wins;
  - if both are valid, the requester not equal to last_grant wins.
REQ-018 On an accept handshake in IDLE, the block SHALL latch a, b, sel and the grant ID, and go to EXEC on the next cycle.
REQ-019 In EXEC, alu_a, alu_b and alu_sel SHALL equal the latched values, and rsp_data SHALL capture alu_out at the end of the cycle.
REQ-020 The FSM SHALL go from EXEC to RESP unconditionally after one cycle.
REQ-021 In RESP, only rspN_valid for the granted requester SHALL be high, and rsp_data SHALL be stable.
REQ-022 The block SHALL hold RESP until the matching rspN_ready is high, then return to IDLE.
REQ-023 On the RESP handshake, the block SHALL update last_grant to the served ID.
REQ-024 On the RESP handshake, ops_done SHALL increment by 1 and wrap modulo 2^CNT_W.
REQ-025 Latency SHALL be: accept in cycle T gives rspN_valid high in cycle T+2 at the earliest.
REQ-026 The next accept SHALL occur no earlier than the cycle after the RESP handshake (no overlap).
REQ-027 In IDLE and RESP, alu_a, alu_b and alu_sel SHALL be 0.
REQ-028 reqN_ready SHALL be 0 in EXEC and RESP.
REQ-029 rspN_ready asserted outside RESP, or for the non-granted requester, SHALL have no effect.
REQ-030 reqN_valid deasserting after acceptance SHALL have no effect on the operation in flight.
REQ-031 rsp_data SHALL hold its last captured value after the response handshake until the next EXEC capture.

Reset
REQ-032 With rst high at a clock edge, the block SHALL go to IDLE and discard any operation in flight, whatever the state.
REQ-033 Reset values SHALL be: rsp0_valid = rsp1_valid = 0, rsp_data = 0, ops_done = 0, busy = 0, and alu_a = alu_b = alu_sel = 0.
REQ-034 Reset SHALL set last_grant = 1, so requester 0 wins the first contention.
REQ-035 While rst is high, req0_ready and req1_ready SHALL be 0.

Verification
REQ-036 The bench SHALL cover single-op latency:
- stimulus: after reset, req0 a=4'b1011, b=4'b0111, sel=3'b000, accepted at cycle T;
- required response: alu_a=1011, alu_b=0111, alu_sel=000 in T+1;
- rsp0_valid=1 in T+2, rsp_data equal to the ALU module's output for those inputs;
- ops_done=1 after rsp0_ready.
REQ-037 The bench SHALL cover contention:
- stimulus: req0 and req1 both valid and held continuously, rsp ready always high;
- required response: grants in order 0,1,0,1, rsp valid in cycles T+2, T+5, T+8, T+11;
- ops_done=4.
REQ-038 The bench SHALL cover response backpressure: rsp1_ready held low for 5 cycles -> rsp1_valid and rsp_data stable, req0_ready=0 throughout, busy=1.
REQ-039 The bench SHALL cover reset mid-operation: rst pulsed in EXEC -> next cycle IDLE, all rsp valids 0, ops_done=0, and req0 wins the next contention.
REQ-040 The bench SHALL cover the opcode sweep: req1 with a=4'b1011, b=4'b0111, sel=000..111 in sequence -> each rsp_data matches the ALU module's output, and ops_done=8.
REQ-041 The bench SHALL cover counter wrap: CNT_W=2, five completed ops -> ops_done sequence 1,2,3,0,1.
